dcache_tag_ctrl: RTL and testbench
==================================

// Module: dcache_tag_ctrl
// PURPOSE
//  Requester-side controller for the 128-entry dCache tag array (write/read port driver).
//  Accepts one load/store lookup at a time, reads the tag entry, and compares it for hit/miss.
//  On a miss it runs dirty-victim writeback and line refill, then updates the entry.
//  Sits between the LSU request port and the tag array / AXI-side line mover.
// PARAMETERS
//  ADDR_W    32  physical address width
//  ENTRY_W   64  tag entry width; must equal tag array DATA_WIDTH
//  OFFSET_W  4   line offset bits (16-byte line)
//  INDEX_W   7   set index bits (128 sets, direct-mapped)
// PORTS
//  i_clk          in   1        clock
//  i_rst_n        in   1        async active-low reset
//  i_req_valid    in   1        lookup request valid
//  o_req_ready    out  1        controller can accept a request (IDLE only)
//  i_req_addr     in   ADDR_W   request address
//  i_req_wr       in   1        1 = store (marks line dirty), 0 = load
//  o_rsp_valid    out  1        lookup finished; line resident
//  o_rsp_hit      out  1        1 = hit on first lookup, 0 = resolved by refill
//  i_rsp_ready    in   1        consumer accepts response
//  o_wb_valid     out  1        victim writeback request, held until i_wb_done
//  o_wb_addr      out  ADDR_W   {victim_tag, index, OFFSET_W'0}
//  i_wb_done      in   1        one-cycle pulse: writeback complete
//  o_rf_valid     out  1        refill request, held until i_rf_done
//  o_rf_addr      out  ADDR_W   {req_tag, index, OFFSET_W'0}
//  i_rf_done      in   1        one-cycle pulse: refill complete
//  o_tag_wen      out  1        tag array write enable
//  o_tag_addr     out  INDEX_W  tag array index
//  o_tag_din      out  ENTRY_W  tag array write data
//  i_tag_dout     in   ENTRY_W  tag array read data (combinational from o_tag_addr)
// BEHAVIOUR
//  Entry format: [63]=valid, [62]=dirty, [TAG_W-1:0]=tag, TAG_W=ADDR_W-INDEX_W-OFFSET_W; other bits 0.
//  Reset: state IDLE; all outputs 0; request register cleared. The array resets to all-invalid independently.
//  IDLE: o_req_ready=1. On i_req_valid, latch addr/wr -> LOOKUP. o_tag_addr = latched index in all non-IDLE states.
//  LOOKUP (1 cycle): hit = valid && tag match.
//   hit & wr & !dirty -> o_tag_wen=1 this cycle, din={1,1,tag}; -> RESP(hit=1).
//   hit otherwise -> RESP(hit=1), no write.
//   miss & valid & dirty -> WBACK. Miss otherwise -> REFILL.
//  WBACK: o_wb_valid=1, address from i_tag_dout tag; on i_wb_done -> REFILL.
//  REFILL: o_rf_valid=1; on i_rf_done -> UPDATE.
//  UPDATE (1 cycle): o_tag_wen=1, din={1,wr,req_tag}; -> RESP(hit=0).
//  RESP: o_rsp_valid=1, o_rsp_hit stable; on i_rsp_ready -> IDLE. Back-to-back: next request is accepted the cycle after the handshake.
//  Done pulses outside WBACK/REFILL are ignored. i_wb_done and i_rf_done arriving in the same cycle while in WBACK advance only to REFILL.
//  o_tag_wen is asserted only in LOOKUP (store hit on a clean line) and in UPDATE; at most one write per request.
//  Async reset mid-operation aborts in any state; wb/rf valid drop immediately; no partial tag write.
// STRUCTURE
//  dcache_pkg: state enum {IDLE,LOOKUP,WBACK,REFILL,UPDATE,RESP}, entry field positions, TAG_W/INDEX_W/OFFSET_W.
//  Request register uses stl_reg (wen = req handshake). The tag array is instanced alongside the controller at the dCache top, not inside it.
// TESTING
//  After reset, load 0x8000_0010 -> miss, no WBACK, o_rf_addr=0x8000_0010, UPDATE writes idx 1 {1,0,tag}, rsp hit=0.
//  Repeat load 0x8000_0010 -> rsp hit=1 two cycles after accept, o_tag_wen never asserted.
//  Store 0x8000_0010 -> hit, o_tag_wen in LOOKUP with dirty=1; a second store produces no write.
//  Load 0x8000_0810 (same idx 1, dirty) -> o_wb_addr=0x8000_0010, then o_rf_addr=0x8000_0810, entry {1,0,new tag}.
//  Hold i_rsp_ready=0 for 5 cycles -> o_rsp_valid/o_rsp_hit stable, o_req_ready=0 throughout.
//  Assert i_rst_n=0 during REFILL -> all outputs 0 that cycle; entry at idx 1 still holds the pre-reset array value; IDLE after release.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and geometry for the dCache tag controller.
//  Revision    : 1.0  initial release
// ============================================================================
package dcache_pkg;

    localparam int DC_ADDR_W    = 32;
    localparam int DC_ENTRY_W   = 64;
    localparam int DC_OFFSET_W  = 4;
    localparam int DC_INDEX_W   = 7;
    localparam int DC_TAG_W     = DC_ADDR_W - DC_INDEX_W - DC_OFFSET_W;

    // Entry field positions: valid and dirty live at the top, tag at the bottom
    localparam int DC_VALID_BIT = DC_ENTRY_W - 1;
    localparam int DC_DIRTY_BIT = DC_ENTRY_W - 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WBACK  = 3'd2,
        ST_REFILL = 3'd3,
        ST_UPDATE = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/stl_reg.sv
`default_nettype none
// ============================================================================
//  Module      : stl_reg
//  Description : Write-enabled register with async active-low clear.
//  Revision    : 1.0  initial release
// ============================================================================
module stl_reg #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Capture i_d when enabled, clear on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= '0;
        end else if (i_wen) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_tag_ctrl
//  Description : Requester-side controller for the direct-mapped dCache tag
//                array: lookup, dirty-victim writeback, refill, entry update.
//  Revision    : 1.0  initial release
// ============================================================================
module dcache_tag_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = DC_ADDR_W,
    parameter int ENTRY_W  = DC_ENTRY_W,
    parameter int OFFSET_W = DC_OFFSET_W,
    parameter int INDEX_W  = DC_INDEX_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [ADDR_W-1:0]  i_req_addr,
    input  logic               i_req_wr,
    output logic               o_rsp_valid,
    output logic               o_rsp_hit,
    input  logic               i_rsp_ready,
    output logic               o_wb_valid,
    output logic [ADDR_W-1:0]  o_wb_addr,
    input  logic               i_wb_done,
    output logic               o_rf_valid,
    output logic [ADDR_W-1:0]  o_rf_addr,
    input  logic               i_rf_done,
    output logic               o_tag_wen,
    output logic [INDEX_W-1:0] o_tag_addr,
    output logic [ENTRY_W-1:0] o_tag_din,
    input  logic [ENTRY_W-1:0] i_tag_dout
);

    localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W;
    localparam int VALID_BIT = ENTRY_W - 1;
    localparam int DIRTY_BIT = ENTRY_W - 2;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_hit;
    logic [ADDR_W:0]    r_req;
    logic               w_req_fire;
    logic [ADDR_W-1:0]  w_req_addr;
    logic               w_req_wr;
    logic [INDEX_W-1:0] w_req_index;
    logic [TAG_W-1:0]   w_req_tag;
    logic               w_ent_valid;
    logic               w_ent_dirty;
    logic [TAG_W-1:0]   w_ent_tag;
    logic               w_hit;
    logic               w_din_dirty;

    // Ready is forced low while reset is held so every output reads 0
    assign o_req_ready = (r_state == ST_IDLE) && i_rst_n;
    assign w_req_fire  = i_req_valid && o_req_ready;

    stl_reg #(
        .WIDTH (ADDR_W + 1)
    ) u_req_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_wen   (w_req_fire),
        .i_d     ({i_req_addr, i_req_wr}),
        .o_q     (r_req)
    );

    assign w_req_addr  = r_req[ADDR_W:1];
    assign w_req_wr    = r_req[0];
    assign w_req_index = w_req_addr[OFFSET_W +: INDEX_W];
    assign w_req_tag   = w_req_addr[ADDR_W-1 -: TAG_W];

    // The array read is combinational from o_tag_addr, so the entry for the
    // latched index is visible in every non-idle state
    assign o_tag_addr  = w_req_index;
    assign w_ent_valid = i_tag_dout[VALID_BIT];
    assign w_ent_dirty = i_tag_dout[DIRTY_BIT];
    assign w_ent_tag   = i_tag_dout[TAG_W-1:0];
    assign w_hit       = w_ent_valid && (w_ent_tag == w_req_tag);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember whether the first lookup hit; a refill always reports a miss
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit <= 1'b0;
        end else if (r_state == ST_LOOKUP) begin
            r_hit <= w_hit;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        o_rsp_valid  = 1'b0;
        o_rsp_hit    = 1'b0;
        o_wb_valid   = 1'b0;
        o_wb_addr    = '0;
        o_rf_valid   = 1'b0;
        o_rf_addr    = '0;
        o_tag_wen    = 1'b0;
        o_tag_din    = '0;
        w_din_dirty  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req_fire) begin
                    w_next_state = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    // Only a store to a clean line changes the entry
                    if (w_req_wr && !w_ent_dirty) begin
                        o_tag_wen   = 1'b1;
                        w_din_dirty = 1'b1;
                    end
                    w_next_state = ST_RESP;
                end else if (w_ent_valid && w_ent_dirty) begin
                    w_next_state = ST_WBACK;
                end else begin
                    w_next_state = ST_REFILL;
                end
            end
            ST_WBACK: begin
                o_wb_valid = 1'b1;
                o_wb_addr  = {w_ent_tag, w_req_index, {OFFSET_W{1'b0}}};
                // A simultaneous refill-done pulse is deliberately ignored here
                if (i_wb_done) begin
                    w_next_state = ST_REFILL;
                end
            end
            ST_REFILL: begin
                o_rf_valid = 1'b1;
                o_rf_addr  = {w_req_tag, w_req_index, {OFFSET_W{1'b0}}};
                if (i_rf_done) begin
                    w_next_state = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                o_tag_wen    = 1'b1;
                w_din_dirty  = w_req_wr;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                o_rsp_valid = 1'b1;
                o_rsp_hit   = r_hit;
                if (i_rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (o_tag_wen) begin
            o_tag_din[VALID_BIT]   = 1'b1;
            o_tag_din[DIRTY_BIT]   = w_din_dirty;
            o_tag_din[TAG_W-1:0]   = w_req_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_tag_ctrl
//  Description : Directed self-checking bench for dcache_tag_ctrl with a
//                behavioural 128-entry tag array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dcache_tag_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wr;
    logic        rsp_valid;
    logic        rsp_hit;
    logic        rsp_ready;
    logic        wb_valid;
    logic [31:0] wb_addr;
    logic        wb_done;
    logic        rf_valid;
    logic [31:0] rf_addr;
    logic        rf_done;
    logic        tag_wen;
    logic [6:0]  tag_addr;
    logic [63:0] tag_din;
    logic [63:0] tag_dout;

    logic [63:0] mem [128];

    int checks;
    int errors;

    localparam logic [63:0] ENT_A_CLEAN = 64'h8000_0000_0010_0000;
    localparam logic [63:0] ENT_A_DIRTY = 64'hC000_0000_0010_0000;
    localparam logic [63:0] ENT_B_CLEAN = 64'h8000_0000_0010_0001;

    dcache_tag_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_addr  (req_addr),
        .i_req_wr    (req_wr),
        .o_rsp_valid (rsp_valid),
        .o_rsp_hit   (rsp_hit),
        .i_rsp_ready (rsp_ready),
        .o_wb_valid  (wb_valid),
        .o_wb_addr   (wb_addr),
        .i_wb_done   (wb_done),
        .o_rf_valid  (rf_valid),
        .o_rf_addr   (rf_addr),
        .i_rf_done   (rf_done),
        .o_tag_wen   (tag_wen),
        .o_tag_addr  (tag_addr),
        .o_tag_din   (tag_din),
        .i_tag_dout  (tag_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tag array: combinational read, synchronous write
    assign tag_dout = mem[tag_addr];
    always @(posedge clk) begin
        if (tag_wen) mem[tag_addr] <= tag_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; reports whether it was accepted
    task automatic issue(input logic [31:0] addr, input logic wr, output logic accepted);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wr    = wr;
        accepted  = req_ready;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({req_ready, rsp_valid, wb_valid, rf_valid, tag_wen} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000", {req_ready, rsp_valid, wb_valid, rf_valid, tag_wen});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_load_miss();
        logic acc;
        // Stray done pulses in IDLE must be ignored
        wb_done = 1'b1; rf_done = 1'b1;
        tick();
        wb_done = 1'b0; rf_done = 1'b0;
        issue(32'h8000_0010, 1'b0, acc);
        checks++;
        if (acc !== 1'b1) begin errors++; $display("FAIL miss_accept: got %b expected 1", acc); end
        checks++;
        if ({tag_addr, tag_wen, wb_valid, rsp_valid} !== {7'd1, 3'b000}) begin
            errors++;
            $display("FAIL miss_lookup: got addr=%0d wen=%b wb=%b rsp=%b expected addr=1 all 0", tag_addr, tag_wen, wb_valid, rsp_valid);
        end
        tick();
        checks++;
        if ({wb_valid, rf_valid, rf_addr} !== {2'b01, 32'h8000_0010}) begin
            errors++;
            $display("FAIL miss_refill: got wb=%b rf=%b rf_addr=%h expected wb=0 rf=1 80000010", wb_valid, rf_valid, rf_addr);
        end
        tick();
        rf_done = 1'b1;
        tick();
        rf_done = 1'b0;
        checks++;
        if ({tag_wen, tag_addr, tag_din} !== {1'b1, 7'd1, ENT_A_CLEAN}) begin
            errors++;
            $display("FAIL miss_update: got wen=%b addr=%0d din=%h expected 1 1 %h", tag_wen, tag_addr, tag_din, ENT_A_CLEAN);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_hit, tag_wen} !== 3'b100 || mem[1] !== ENT_A_CLEAN) begin
            errors++;
            $display("FAIL miss_resp: got v=%b hit=%b wen=%b mem=%h expected 100 %h", rsp_valid, rsp_hit, tag_wen, mem[1], ENT_A_CLEAN);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL miss_back_idle: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_hit();
        logic acc;
        logic saw_wen;
        issue(32'h8000_0010, 1'b0, acc);
        saw_wen = tag_wen;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_early_rsp: got %b expected 0", rsp_valid); end
        tick();
        saw_wen = saw_wen | tag_wen;
        checks++;
        if ({rsp_valid, rsp_hit, saw_wen} !== 3'b110) begin
            errors++;
            $display("FAIL hit_resp: got v=%b hit=%b wen_seen=%b expected 110", rsp_valid, rsp_hit, saw_wen);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_store_hit();
        logic acc;
        issue(32'h8000_0010, 1'b1, acc);
        checks++;
        if ({tag_wen, tag_din} !== {1'b1, ENT_A_DIRTY}) begin
            errors++;
            $display("FAIL store_clean_wen: got wen=%b din=%h expected 1 %h", tag_wen, tag_din, ENT_A_DIRTY);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_hit, tag_wen} !== 3'b110 || mem[1] !== ENT_A_DIRTY) begin
            errors++;
            $display("FAIL store_clean_resp: got v=%b hit=%b wen=%b mem=%h expected 110 %h", rsp_valid, rsp_hit, tag_wen, mem[1], ENT_A_DIRTY);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        issue(32'h8000_0010, 1'b1, acc);
        checks++;
        if (tag_wen !== 1'b0) begin errors++; $display("FAIL store_dirty_nowen: got %b expected 0", tag_wen); end
        tick();
        checks++;
        if ({rsp_valid, rsp_hit, tag_wen} !== 3'b110) begin
            errors++;
            $display("FAIL store_dirty_resp: got %b expected 110", {rsp_valid, rsp_hit, tag_wen});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_dirty_miss();
        logic acc;
        issue(32'h8000_0810, 1'b0, acc);
        checks++;
        if (tag_wen !== 1'b0) begin errors++; $display("FAIL dmiss_lookup_wen: got %b expected 0", tag_wen); end
        tick();
        checks++;
        if ({wb_valid, rf_valid, wb_addr} !== {2'b10, 32'h8000_0010}) begin
            errors++;
            $display("FAIL dmiss_wback: got wb=%b rf=%b wb_addr=%h expected 1 0 80000010", wb_valid, rf_valid, wb_addr);
        end
        // Both done pulses together must only advance to REFILL
        wb_done = 1'b1; rf_done = 1'b1;
        tick();
        wb_done = 1'b0; rf_done = 1'b0;
        checks++;
        if ({wb_valid, rf_valid, tag_wen, rf_addr} !== {3'b010, 32'h8000_0810}) begin
            errors++;
            $display("FAIL dmiss_refill: got wb=%b rf=%b wen=%b rf_addr=%h expected 0 1 0 80000810", wb_valid, rf_valid, tag_wen, rf_addr);
        end
        rf_done = 1'b1;
        tick();
        rf_done = 1'b0;
        checks++;
        if ({tag_wen, tag_din} !== {1'b1, ENT_B_CLEAN}) begin
            errors++;
            $display("FAIL dmiss_update: got wen=%b din=%h expected 1 %h", tag_wen, tag_din, ENT_B_CLEAN);
        end
        tick();
        // Response must hold while the consumer stalls
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, rsp_hit, req_ready} !== 3'b100) begin
                errors++;
                $display("FAIL dmiss_stall[%0d]: got v=%b hit=%b rdy=%b expected 100", i, rsp_valid, rsp_hit, req_ready);
            end
            tick();
        end
        checks++;
        if (mem[1] !== ENT_B_CLEAN) begin
            errors++;
            $display("FAIL dmiss_entry: got %h expected %h", mem[1], ENT_B_CLEAN);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic acc;
        issue(32'h8000_0810, 1'b0, acc);
        tick();
        // Handshake the response while a new request is already waiting
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h8000_0810;
        req_wr    = 1'b0;
        checks++;
        if ({rsp_valid, rsp_hit, req_ready} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_resp: got %b expected 110", {rsp_valid, rsp_hit, req_ready});
        end
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_lookup: got rdy=%b rsp=%b expected 00", req_ready, rsp_valid);
        end
        tick();
        checks++;
        if ({rsp_valid, rsp_hit} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_second_resp: got %b expected 11", {rsp_valid, rsp_hit});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_refill();
        logic acc;
        issue(32'h8000_0010, 1'b0, acc);
        tick();
        checks++;
        if (rf_valid !== 1'b1) begin errors++; $display("FAIL rstmid_in_refill: got %b expected 1", rf_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_hit, wb_valid, rf_valid, tag_wen, wb_addr, rf_addr, tag_addr, tag_din} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got rdy=%b rsp=%b hit=%b wb=%b rf=%b wen=%b rf_addr=%h tag_addr=%0d expected all 0",
                     req_ready, rsp_valid, rsp_hit, wb_valid, rf_valid, tag_wen, rf_addr, tag_addr);
        end
        rf_done = 1'b1;
        tick();
        rf_done = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (mem[1] !== ENT_B_CLEAN) begin
            errors++;
            $display("FAIL rstmid_entry: got %h expected %h", mem[1], ENT_B_CLEAN);
        end
        checks++;
        if ({req_ready, rf_valid, tag_wen} !== 3'b100) begin
            errors++;
            $display("FAIL rstmid_idle: got %b expected 100", {req_ready, rf_valid, tag_wen});
        end
        // Controller must work normally after the abort
        issue(32'h8000_0810, 1'b0, acc);
        tick();
        checks++;
        if ({acc, rsp_valid, rsp_hit} !== 3'b111) begin
            errors++;
            $display("FAIL rstmid_after: got %b expected 111", {acc, rsp_valid, rsp_hit});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wr    = 1'b0;
        rsp_ready = 1'b0;
        wb_done   = 1'b0;
        rf_done   = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #1;

        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_dirty_miss();
        test_back_to_back();
        test_reset_mid_refill();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
